// File: rtl/ahb_decoder_mux_if.sv
// AHB-Lite bus bundle between the Cortex-M0 master side and the three slave slots.
// The decoder/mux connects through the slave modport and the surrounding bus through master.
interface ahb_decoder_mux_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_S0;
    logic        HSEL_S1;
    logic        HSEL_S2;
    logic [31:0] HRDATA_S0;
    logic [31:0] HRDATA_S1;
    logic [31:0] HRDATA_S2;
    logic        HRESP_S0;
    logic        HRESP_S1;
    logic        HRESP_S2;
    logic        HREADYOUT_S0;
    logic        HREADYOUT_S1;
    logic        HREADYOUT_S2;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        HREADY;

    modport slave (
        input  HADDR, HTRANS,
        input  HRDATA_S0, HRDATA_S1, HRDATA_S2,
        input  HRESP_S0, HRESP_S1, HRESP_S2,
        input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
        output HSEL_S0, HSEL_S1, HSEL_S2,
        output HRDATA, HRESP, HREADY
    );

    modport master (
        output HADDR, HTRANS,
        output HRDATA_S0, HRDATA_S1, HRDATA_S2,
        output HRESP_S0, HRESP_S1, HRESP_S2,
        output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
        input  HSEL_S0, HSEL_S1, HSEL_S2,
        input  HRDATA, HRESP, HREADY
    );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response mux for ROM/SRAM/peripheral slots plus default slave.
// Define AHB_DEFSLV_ERROR_EN for a two-cycle ERROR on unmapped transfers; otherwise fill-pattern OKAY.
module ahb_decoder_mux #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_decoder_mux_if.slave  bus
);
    localparam logic [2:0][15:0] BASE_HI = {S2_BASE[31:16], S1_BASE[31:16], S0_BASE[31:16]};
    localparam logic [1:0]       SEL_DEF = 2'd3;

    logic [2:0]  hit;
    logic        hsel_def;
    logic [1:0]  dec_sel;
    logic [1:0]  dsel_reg;
    logic        def_ready;
    logic        def_resp;
    logic [31:0] def_rdata;
    logic        hready_mux;
    logic        hresp_mux;
    logic [31:0] hrdata_mux;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_decode
            assign hit[gi] = (bus.HADDR[31:16] == BASE_HI[gi]);
        end
    endgenerate

    assign bus.HSEL_S0 = hit[0];
    assign bus.HSEL_S1 = hit[1];
    assign bus.HSEL_S2 = hit[2];
    assign hsel_def    = ~|hit;

    always_comb begin
        dec_sel = SEL_DEF;
        if (hit[0])      dec_sel = 2'd0;
        else if (hit[1]) dec_sel = 2'd1;
        else if (hit[2]) dec_sel = 2'd2;
    end

    // Data-phase owner only advances when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            dsel_reg <= SEL_DEF;
        else if (hready_mux)
            dsel_reg <= dec_sel;
    end

`ifdef AHB_DEFSLV_ERROR_EN
    typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t ds_state_reg;
    logic      def_ready_reg;
    logic      def_resp_reg;

    // Outputs are registered alongside the state so each state's ready/resp appear with it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ds_state_reg  <= DS_OK;
            def_ready_reg <= 1'b1;
            def_resp_reg  <= 1'b0;
        end else begin
            case (ds_state_reg)
                DS_OK: begin
                    if (hsel_def && bus.HTRANS[1] && hready_mux) begin
                        ds_state_reg  <= DS_ERR1;
                        def_ready_reg <= 1'b0;
                        def_resp_reg  <= 1'b1;
                    end
                end
                DS_ERR1: begin
                    ds_state_reg  <= DS_ERR2;
                    def_ready_reg <= 1'b1;
                    def_resp_reg  <= 1'b1;
                end
                DS_ERR2: begin
                    if (hsel_def && bus.HTRANS[1]) begin
                        ds_state_reg  <= DS_ERR1;
                        def_ready_reg <= 1'b0;
                        def_resp_reg  <= 1'b1;
                    end else begin
                        ds_state_reg  <= DS_OK;
                        def_ready_reg <= 1'b1;
                        def_resp_reg  <= 1'b0;
                    end
                end
                default: begin
                    ds_state_reg  <= DS_OK;
                    def_ready_reg <= 1'b1;
                    def_resp_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign def_ready = def_ready_reg;
    assign def_resp  = def_resp_reg;
    assign def_rdata = 32'h0000_0000;
`else
    assign def_ready = 1'b1;
    assign def_resp  = 1'b0;
    assign def_rdata = 32'hCCCC_CCCC;
`endif

    always_comb begin
        hready_mux = def_ready;
        hresp_mux  = def_resp;
        hrdata_mux = def_rdata;
        case (dsel_reg)
            2'd0: begin
                hready_mux = bus.HREADYOUT_S0;
                hresp_mux  = bus.HRESP_S0;
                hrdata_mux = bus.HRDATA_S0;
            end
            2'd1: begin
                hready_mux = bus.HREADYOUT_S1;
                hresp_mux  = bus.HRESP_S1;
                hrdata_mux = bus.HRDATA_S1;
            end
            2'd2: begin
                hready_mux = bus.HREADYOUT_S2;
                hresp_mux  = bus.HRESP_S2;
                hrdata_mux = bus.HRDATA_S2;
            end
            default: ;
        endcase
    end

    assign bus.HREADY = hready_mux;
    assign bus.HRESP  = hresp_mux;
    assign bus.HRDATA = hrdata_mux;
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: directed test-plan steps then randomized traffic
// compared against a transaction-level model of decode, data-phase ownership and default slave.
module tb_ahb_decoder_mux;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;

    ahb_decoder_mux_if bus();

    ahb_decoder_mux dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

`ifdef AHB_DEFSLV_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: which slot owns the current data phase, and how many error cycles remain.
    int owner    = 3;
    int err_left = 0;

    logic [31:0] s_rdata [3];
    logic        s_resp  [3];
    logic        s_ready [3];

    logic [31:0] obs_rdata;
    logic        obs_resp;
    logic        obs_ready;
    logic [2:0]  obs_hsel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        case (a[31:16])
            16'h0000: return 0;
            16'h2000: return 1;
            16'h4000: return 2;
            default:  return 3;
        endcase
    endfunction

    task automatic drive_slaves();
        bus.HRDATA_S0 = s_rdata[0]; bus.HRDATA_S1 = s_rdata[1]; bus.HRDATA_S2 = s_rdata[2];
        bus.HRESP_S0  = s_resp[0];  bus.HRESP_S1  = s_resp[1];  bus.HRESP_S2  = s_resp[2];
        bus.HREADYOUT_S0 = s_ready[0]; bus.HREADYOUT_S1 = s_ready[1]; bus.HREADYOUT_S2 = s_ready[2];
    endtask

    task automatic set_slave(input int i, input logic [31:0] d, input logic r, input logic rdy);
        s_rdata[i] = d; s_resp[i] = r; s_ready[i] = rdy;
    endtask

    // One bus cycle: inputs are already applied; check at negedge, advance model at posedge.
    task automatic cycle(input string tag);
        int d;
        logic        e_ready, e_resp;
        logic [31:0] e_rdata;
        drive_slaves();
        @(negedge HCLK);
        d = decode(bus.HADDR);
        obs_rdata = bus.HRDATA; obs_resp = bus.HRESP; obs_ready = bus.HREADY;
        obs_hsel  = {bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};
        if (owner < 3) begin
            e_ready = s_ready[owner]; e_resp = s_resp[owner]; e_rdata = s_rdata[owner];
        end else if (ERR_EN) begin
            e_ready = (err_left != 2); e_resp = (err_left != 0); e_rdata = 32'h0;
        end else begin
            e_ready = 1'b1; e_resp = 1'b0; e_rdata = 32'hCCCC_CCCC;
        end
        chk({tag, ".hsel"},   {29'd0, obs_hsel}, {29'd0, d == 2, d == 1, d == 0});
        chk({tag, ".hready"}, {31'd0, obs_ready}, {31'd0, e_ready});
        chk({tag, ".hresp"},  {31'd0, obs_resp},  {31'd0, e_resp});
        chk({tag, ".hrdata"}, obs_rdata, e_rdata);
        $display("cycle %-10s rst_n=%0b addr=%h trans=%0d owner=%0d ready=%0b resp=%0b rdata=%h",
                 tag, HRESETn, bus.HADDR, bus.HTRANS, owner, obs_ready, obs_resp, obs_rdata);
        @(posedge HCLK);
        if (!HRESETn) begin
            owner = 3; err_left = 0;
        end else if (e_ready) begin
            owner = d;
            err_left = (ERR_EN && d == 3 && bus.HTRANS[1]) ? 2 : 0;
        end else if (err_left == 2) begin
            err_left = 1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_slave(i, 32'h0, 1'b0, 1'b0);
        drive_slaves();
        bus.HADDR = 32'h6000_0000; bus.HTRANS = 2'b00;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;

        // Reset held with all slaves stalling.
        for (int i = 0; i < 3; i++) cycle("reset");
        chk("rst.hready", {31'd0, obs_ready}, 32'd1);
        chk("rst.hresp",  {31'd0, obs_resp},  32'd0);
        chk("rst.hrdata", obs_rdata, ERR_EN ? 32'h0 : 32'hCCCC_CCCC);

        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) set_slave(i, 32'h0, 1'b0, 1'b1);

        // ROM read.
        bus.HADDR = 32'h0000_0004; bus.HTRANS = 2'b10;
        cycle("rom_addr");
        chk("rom.hsel0", {29'd0, obs_hsel}, 32'd1);
        bus.HADDR = 32'h0000_0000; bus.HTRANS = 2'b00;
        set_slave(0, 32'h0000_0009, 1'b0, 1'b1);
        cycle("rom_data");
        chk("rom.hrdata", obs_rdata, 32'h0000_0009);

        // SRAM read with two wait states, ROM address pipelined behind it.
        bus.HADDR = 32'h2000_0010; bus.HTRANS = 2'b10;
        cycle("sram_addr");
        bus.HADDR = 32'h0000_0008; bus.HTRANS = 2'b10;
        set_slave(1, 32'h1234_5678, 1'b0, 1'b0);
        cycle("sram_w1");
        chk("sram.w1", {31'd0, obs_ready}, 32'd0);
        cycle("sram_w2");
        chk("sram.w2", {31'd0, obs_ready}, 32'd0);
        set_slave(1, 32'h1234_5678, 1'b0, 1'b1);
        cycle("sram_data");
        chk("sram.hrdata", obs_rdata, 32'h1234_5678);
        bus.HADDR = 32'h0000_0000; bus.HTRANS = 2'b00;
        set_slave(0, 32'hBF40_4600, 1'b0, 1'b1);
        cycle("rom2_data");
        chk("rom2.hrdata", obs_rdata, 32'hBF40_4600);

        // Unmapped NONSEQ then IDLE.
        bus.HADDR = 32'h6000_0000; bus.HTRANS = 2'b10;
        cycle("unm_addr");
        bus.HTRANS = 2'b00;
        cycle("unm_d1");
        chk("unm.d1.ready", {31'd0, obs_ready}, ERR_EN ? 32'd0 : 32'd1);
        chk("unm.d1.resp",  {31'd0, obs_resp},  ERR_EN ? 32'd1 : 32'd0);
        cycle("unm_d2");
        chk("unm.d2.resp",  {31'd0, obs_resp},  ERR_EN ? 32'd1 : 32'd0);
        cycle("unm_d3");
        chk("unm.d3.resp",  {31'd0, obs_resp},  32'd0);

        // Back-to-back unmapped NONSEQ.
        bus.HTRANS = 2'b10;
        for (int i = 0; i < 5; i++) cycle("unm_b2b");
        bus.HTRANS = 2'b00;
        cycle("unm_b2b_end");

        // Reset asserted during the first error cycle.
        bus.HTRANS = 2'b10;
        cycle("rerr_addr");
        bus.HTRANS = 2'b00;
        HRESETn = 1'b0;
        cycle("rerr_err1");
        HRESETn = 1'b1;
        cycle("rerr_after");
        chk("rerr.ready", {31'd0, obs_ready}, 32'd1);
        chk("rerr.resp",  {31'd0, obs_resp},  32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int region;
            logic [31:0] hi;
            region = $urandom_range(0, 4);
            case (region)
                0: hi = 32'h0000_0000;
                1: hi = 32'h2000_0000;
                2: hi = 32'h4000_0000;
                3: hi = 32'h6000_0000;
                default: hi = {$urandom_range(0, 16'hFFFF), 16'h0};
            endcase
            bus.HADDR  = hi | ($urandom & 32'h0000_FFFC);
            bus.HTRANS = 2'($urandom_range(0, 3));
            HRESETn    = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < 3; i++)
                set_slave(i, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
